writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Sole writer of the integer register file write port (write_en/write_addr/write_data).
//  Merges single-cycle ALU results with variable-latency load responses from memory.
//  Buffers ALU results that lose arbitration.
//  Keeps a pending-load scoreboard that decode uses for RAW/WAW stall decisions.
// PARAMETERS
//  XLEN          32  data width of results and register file write data
//  ALU_BUF_DEPTH 2   entries in ALU result buffer (>=1, power of two)
// PORTS
//  clk              in   1     rising-edge clock
//  rst              in   1     asynchronous, active-low reset
//  alu_valid        in   1     ALU result offered this cycle
//  alu_ready        out  1     ALU result accepted when alu_valid && alu_ready
//  alu_rd           in   5     ALU destination register
//  alu_data         in   XLEN  ALU result
//  load_issue_valid in   1     decode issued a load this cycle
//  load_issue_rd    in   5     destination of issued load
//  mem_resp_valid   in   1     load data returning; always accepted, no backpressure
//  mem_resp_rd      in   5     destination of returning load
//  mem_resp_data    in   XLEN  load data (already sign/zero extended)
//  write_en         out  1     register file write enable
//  write_addr       out  5     register file write address
//  write_data       out  XLEN  register file write data
//  pending          out  32    bit n = load to xn outstanding; bit 0 always 0
//  err              out  1     sticky protocol error flag
// BEHAVIOUR
//  Reset (rst==0, asynchronous):
//   - write_en=0, write_addr=0, write_data=0, pending=0, err=0.
//   - Buffer is empty, so alu_ready=1 once out of reset.
//  Write port:
//   - write_en/write_addr/write_data are registered.
//   - An accepted or selected source appears on the port exactly 1 cycle later, held for 1 cycle.
//  Arbitration each cycle, fixed priority:
//   - 1st: mem_resp.
//   - 2nd: buffer head.
//   - 3rd: new ALU result, bypassing the buffer only when the buffer is empty.
//   - An accepted ALU result that is not selected is pushed to the buffer tail.
//   - Buffer order is FIFO, so ALU results write in acceptance order.
//  alu_ready:
//   - alu_ready = (buffer count < ALU_BUF_DEPTH), derived from registered count only.
//   - It is not a function of alu_valid or mem_resp_valid.
//   - When the buffer is full and an entry drains, ready rises the next cycle.
//  Simultaneous push and pop with count==DEPTH: cannot occur because ready=0. With count<DEPTH: the count is unchanged.
//  rd==0 handling:
//   - Any source with rd==0 is consumed: popped, or accepted and dropped.
//   - It never asserts write_en.
//   - It still occupies its arbitration slot, so order is preserved.
//  Scoreboard:
//   - load_issue_valid && rd!=0 sets pending[rd].
//   - mem_resp_valid clears pending[mem_resp_rd].
//   - The update is registered, visible next cycle.
//   - Same-cycle set and clear on the same rd: set wins (a new load replaces the returning one).
//  err is set (sticky until reset) on any of:
//   - mem_resp_valid with pending[mem_resp_rd]==0 and rd!=0.
//   - load_issue_valid to an rd already pending with no clear this cycle.
//  Ordering (no hazard check in this block):
//   - Decode guarantees no ALU result targets an rd whose pending bit is set.
//   - Decode also guarantees no load issue targets an rd with a buffered ALU write.
//  Reset mid-operation: buffer contents, pending bits and any in-flight write are discarded. No write occurs in the reset cycle.
// STRUCTURE
//  Shared package riscv_pkg:
//   - XLEN=32, REG_ADDR_W=5, NUM_REGS=32.
//   - Typedef wb_req_t {rd[4:0], data[XLEN-1:0]}.
//  Sub-module wb_result_fifo:
//   - Parameterized depth; push/pop/full/empty/count.
//   - Async active-low reset.
//  Top level holds the arbiter mux, output registers, scoreboard and err logic.
// TESTING
//  1 Reset: hold rst=0 with random inputs.
//    -> All outputs are 0, alu_ready=1.
//    -> After release, first write_en only after a valid source.
//  2 ALU only, back-to-back x5=0x11, x6=0x22, x7=0x33.
//    -> write_en pulses on cycles N+1..N+3 with those addr/data.
//    -> alu_ready stays 1.
//  3 Load issue x9 at cycle 0.
//    -> pending[9]=1 from cycle 1.
//    -> mem_resp x9=0xDEADBEEF at cycle 4 gives a write at cycle 5 and pending[9]=0 at cycle 5.
//  4 Collision: mem_resp x3=0xA and alu x4=0xB in same cycle, then alu x8=0xC next cycle.
//    -> Writes x3, x4, x8 in consecutive cycles.
//  5 Full buffer (DEPTH=2): four consecutive mem_resp cycles while ALU presents x10..x13.
//    -> alu_ready falls after 2 accepts.
//    -> Order is x10,x11,x12,x13 after responses drain.
//    -> No results lost or duplicated.
//  6 Edges:
//    -> alu x0=0xFF: no write_en.
//    -> Same-cycle issue and resp on x12: pending[12] stays 1.
//    -> Resp to non-pending x20: err=1 and it stays set until rst.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared integer-core definitions: register file geometry and the writeback request record.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO holding ALU results that lost writeback arbitration; head is valid whenever !empty.
module wb_result_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  output wb_req_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: count/pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

endmodule

// File: rtl/writeback_unit.sv
// Register file write-port owner: arbitrates load responses, buffered and fresh ALU results,
// and tracks outstanding loads for decode's hazard checks.
module writeback_unit #(
  parameter int XLEN          = riscv_pkg::XLEN,
  parameter int ALU_BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  // ALU handshake: a result transfers on a cycle where alu_valid && alu_ready; alu_ready
  // depends only on registered buffer occupancy, never on alu_valid or mem_resp_valid.
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            load_issue_valid,
  input  logic [4:0]      load_issue_rd,
  input  logic            mem_resp_valid,
  input  logic [4:0]      mem_resp_rd,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            write_en,
  output logic [4:0]      write_addr,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     pending,
  output logic            err
);

  localparam int CNT_W = $clog2(ALU_BUF_DEPTH + 1);

  riscv_pkg::wb_req_t alu_req;
  riscv_pkg::wb_req_t head_req;
  riscv_pkg::wb_req_t sel_req;
  logic               sel_valid;
  logic               wr_fire;
  logic               alu_acc;
  logic               fifo_push;
  logic               fifo_pop;
  logic               buf_full;
  logic               buf_empty;
  logic [CNT_W-1:0]   buf_count;
  logic [31:0]        pending_d;
  logic               err_d;

  assign alu_req.rd   = alu_rd;
  assign alu_req.data = alu_data;
  assign alu_ready    = (buf_count < CNT_W'(ALU_BUF_DEPTH));
  assign alu_acc      = alu_valid && alu_ready;

  wb_result_fifo #(
    .DEPTH(ALU_BUF_DEPTH)
  ) u_alu_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_req (alu_req),
    .pop      (fifo_pop),
    .head     (head_req),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (buf_count)
  );

  // Fixed priority: load response, then buffer head, then a fresh ALU result (bypass only
  // when nothing is buffered, which keeps ALU writes in acceptance order).
  always_comb begin
    sel_valid = 1'b0;
    sel_req   = '0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (mem_resp_valid) begin
      sel_valid    = 1'b1;
      sel_req.rd   = mem_resp_rd;
      sel_req.data = mem_resp_data;
      fifo_push    = alu_acc && !buf_full;
    end else if (!buf_empty) begin
      sel_valid = 1'b1;
      sel_req   = head_req;
      fifo_pop  = 1'b1;
      fifo_push = alu_acc && !buf_full;
    end else if (alu_acc) begin
      sel_valid = 1'b1;
      sel_req   = alu_req;
    end
  end

  // x0 sources still consume their slot but never reach the register file.
  assign wr_fire = sel_valid && (sel_req.rd != '0);

  // Set is applied after clear so a reissued load to the returning rd stays pending.
  always_comb begin
    pending_d = pending;
    err_d     = err;
    if (mem_resp_valid) begin
      pending_d[mem_resp_rd] = 1'b0;
      if (mem_resp_rd != '0 && !pending[mem_resp_rd]) err_d = 1'b1;
    end
    if (load_issue_valid && load_issue_rd != '0) begin
      pending_d[load_issue_rd] = 1'b1;
      if (pending[load_issue_rd] && !(mem_resp_valid && mem_resp_rd == load_issue_rd))
        err_d = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      pending    <= '0;
      err        <= 1'b0;
    end else begin
      write_en   <= wr_fire;
      write_addr <= wr_fire ? sel_req.rd : '0;
      write_data <= wr_fire ? sel_req.data : '0;
      pending    <= pending_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, ALU streaming, loads, collisions, full buffer, edges.
module tb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        load_issue_valid;
  logic [4:0]  load_issue_rd;
  logic        mem_resp_valid;
  logic [4:0]  mem_resp_rd;
  logic [31:0] mem_resp_data;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] pending;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] exp_q[$];

  writeback_unit #(
    .XLEN          (32),
    .ALU_BUF_DEPTH (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .load_issue_valid (load_issue_valid),
    .load_issue_rd    (load_issue_rd),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_rd      (mem_resp_rd),
    .mem_resp_data    (mem_resp_data),
    .write_en         (write_en),
    .write_addr       (write_addr),
    .write_data       (write_data),
    .pending          (pending),
    .err              (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid        = 1'b0;
    alu_rd           = '0;
    alu_data         = '0;
    load_issue_valid = 1'b0;
    load_issue_rd    = '0;
    mem_resp_valid   = 1'b0;
    mem_resp_rd      = '0;
    mem_resp_data    = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic drive_resp(input logic [4:0] rd, input logic [31:0] d);
    mem_resp_valid = 1'b1;
    mem_resp_rd    = rd;
    mem_resp_data  = d;
  endtask

  task automatic drive_issue(input logic [4:0] rd);
    load_issue_valid = 1'b1;
    load_issue_rd    = rd;
  endtask

  // scoreboard checks
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] a,
                        input logic [31:0] d);
    chk({tag, "_en"}, 64'(write_en), 64'(en));
    if (en) begin
      chk({tag, "_addr"}, 64'(write_addr), 64'(a));
      chk({tag, "_data"}, 64'(write_data), 64'(d));
    end
  endtask

  initial begin
    bit [7:0]    exp_ready;
    int          alu_idx;
    logic        accepted;
    logic [36:0] e;

    // 1: reset with random inputs
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      alu_valid        = 1'($urandom_range(0, 1));
      alu_rd           = 5'($urandom_range(0, 31));
      alu_data         = $urandom;
      load_issue_valid = 1'($urandom_range(0, 1));
      load_issue_rd    = 5'($urandom_range(0, 31));
      mem_resp_valid   = 1'($urandom_range(0, 1));
      mem_resp_rd      = 5'($urandom_range(0, 31));
      mem_resp_data    = $urandom;
      cyc();
      chk("rst_write_en", 64'(write_en), 64'(0));
      chk("rst_write_addr", 64'(write_addr), 64'(0));
      chk("rst_write_data", 64'(write_data), 64'(0));
      chk("rst_pending", 64'(pending), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_alu_ready", 64'(alu_ready), 64'(1));
    end
    idle_inputs();
    rst = 1'b1;
    cyc();
    chk_wr("post_rst0", 1'b0, '0, '0);
    cyc();
    chk_wr("post_rst1", 1'b0, '0, '0);
    chk("post_rst_ready", 64'(alu_ready), 64'(1));

    // 2: back-to-back ALU results
    drive_alu(5'd5, 32'h11);
    chk("t2_ready0", 64'(alu_ready), 64'(1));
    cyc();
    chk_wr("t2_x5", 1'b1, 5'd5, 32'h11);
    drive_alu(5'd6, 32'h22);
    chk("t2_ready1", 64'(alu_ready), 64'(1));
    cyc();
    chk_wr("t2_x6", 1'b1, 5'd6, 32'h22);
    drive_alu(5'd7, 32'h33);
    chk("t2_ready2", 64'(alu_ready), 64'(1));
    cyc();
    chk_wr("t2_x7", 1'b1, 5'd7, 32'h33);
    idle_inputs();
    cyc();
    chk_wr("t2_idle", 1'b0, '0, '0);

    // 3: load x9, response four cycles later
    drive_issue(5'd9);
    cyc();
    idle_inputs();
    chk("t3_pend_c1", 64'(pending), 64'(32'h0000_0200));
    chk_wr("t3_c1", 1'b0, '0, '0);
    cyc();
    cyc();
    chk("t3_pend_c3", 64'(pending), 64'(32'h0000_0200));
    cyc();
    drive_resp(5'd9, 32'hDEAD_BEEF);
    cyc();
    idle_inputs();
    chk_wr("t3_c5", 1'b1, 5'd9, 32'hDEAD_BEEF);
    chk("t3_pend_c5", 64'(pending), 64'(0));
    chk("t3_err", 64'(err), 64'(0));

    // 4: collision between load response and ALU result
    drive_issue(5'd3);
    cyc();
    idle_inputs();
    chk("t4_pend", 64'(pending), 64'(32'h0000_0008));
    drive_resp(5'd3, 32'hA);
    drive_alu(5'd4, 32'hB);
    chk("t4_ready", 64'(alu_ready), 64'(1));
    cyc();
    idle_inputs();
    chk_wr("t4_x3", 1'b1, 5'd3, 32'hA);
    drive_alu(5'd8, 32'hC);
    chk("t4_ready2", 64'(alu_ready), 64'(1));
    cyc();
    idle_inputs();
    chk_wr("t4_x4", 1'b1, 5'd4, 32'hB);
    cyc();
    chk_wr("t4_x8", 1'b1, 5'd8, 32'hC);
    cyc();
    chk_wr("t4_idle", 1'b0, '0, '0);
    chk("t4_err", 64'(err), 64'(0));

    // 5: buffer fills behind four load responses
    for (int i = 0; i < 4; i++) begin
      drive_issue(5'(21 + i));
      cyc();
    end
    idle_inputs();
    chk("t5_pend", 64'(pending), 64'(32'h01E0_0000));
    exp_ready = 8'b1110_0011;
    alu_idx   = 0;
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      if (c < 4) drive_resp(5'(21 + c), 32'(32'h2000 + c));
      if (alu_idx < 4) drive_alu(5'(10 + alu_idx), 32'(32'h100 + 10 + alu_idx));
      chk($sformatf("t5_ready_c%0d", c), 64'(alu_ready), 64'(exp_ready[c]));
      accepted = alu_valid && alu_ready;
      cyc();
      if (accepted) begin
        exp_q.push_back({alu_rd, alu_data});
        alu_idx++;
      end
      if (c < 4) begin
        chk_wr($sformatf("t5_resp_c%0d", c), 1'b1, 5'(21 + c), 32'(32'h2000 + c));
      end else begin
        chk($sformatf("t5_qnonempty_c%0d", c), 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk_wr($sformatf("t5_alu_c%0d", c), 1'b1, e[36:32], e[31:0]);
        end
      end
    end
    idle_inputs();
    cyc();
    chk_wr("t5_drained", 1'b0, '0, '0);
    chk("t5_all_accepted", 64'(alu_idx), 64'(4));
    chk("t5_q_empty", 64'(exp_q.size()), 64'(0));
    chk("t5_pend_clear", 64'(pending), 64'(0));
    chk("t5_err", 64'(err), 64'(0));

    // 6: edges
    drive_alu(5'd0, 32'hFF);
    cyc();
    idle_inputs();
    chk("t6_x0_no_write", 64'(write_en), 64'(0));
    chk("t6_x0_ready", 64'(alu_ready), 64'(1));

    drive_issue(5'd12);
    cyc();
    idle_inputs();
    chk("t6_pend12_set", 64'(pending), 64'(32'h0000_1000));
    drive_issue(5'd12);
    drive_resp(5'd12, 32'h1212);
    cyc();
    idle_inputs();
    chk("t6_pend12_kept", 64'(pending), 64'(32'h0000_1000));
    chk_wr("t6_x12_write", 1'b1, 5'd12, 32'h1212);
    chk("t6_err_clean", 64'(err), 64'(0));
    drive_resp(5'd12, 32'h2121);
    cyc();
    idle_inputs();
    chk("t6_pend12_clr", 64'(pending), 64'(0));
    chk("t6_err_clean2", 64'(err), 64'(0));

    drive_resp(5'd20, 32'h20);
    cyc();
    idle_inputs();
    chk("t6_err_set", 64'(err), 64'(1));
    cyc();
    cyc();
    chk("t6_err_sticky", 64'(err), 64'(1));

    // reset mid-operation discards buffer, pending bits and in-flight write
    drive_issue(5'd7);
    cyc();
    idle_inputs();
    drive_resp(5'd7, 32'h77);
    drive_issue(5'd14);
    drive_alu(5'd15, 32'hF5);
    cyc();
    idle_inputs();
    chk_wr("t7_x7", 1'b1, 5'd7, 32'h77);
    chk("t7_pend14", 64'(pending), 64'(32'h0000_4000));
    drive_alu(5'd16, 32'hF6);
    rst = 1'b0;
    #1;
    chk("t7_rst_wen", 64'(write_en), 64'(0));
    chk("t7_rst_pend", 64'(pending), 64'(0));
    chk("t7_rst_err", 64'(err), 64'(0));
    cyc();
    chk("t7_rst_wen2", 64'(write_en), 64'(0));
    idle_inputs();
    rst = 1'b1;
    cyc();
    chk_wr("t7_after0", 1'b0, '0, '0);
    cyc();
    chk_wr("t7_after1", 1'b0, '0, '0);
    chk("t7_ready", 64'(alu_ready), 64'(1));
    chk("t7_err", 64'(err), 64'(0));

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
